spi_xfer_ctrl: RTL and testbench

Sequencer for the SPI master shift datapath. It accepts a one-word transfer request, drives the shift register's control strobes (enable, load, shift-edge flag, word-complete flag, direction), and generates SCLK and chip select. It sits between the host-side register interface and the shift register, and runs one word per Start.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_xfer_ctrl_if.sv | 30 +++
 rtl/spi_sclk_gen.sv | 52 +++++
 rtl/spi_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master control path and shift register.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_e;

    // Word length shared with the shift register so both sides agree.
    localparam int unsigned WORD_LEN  = 8;
    localparam int unsigned DIV_WIDTH = 8;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host request / shift-register strobe bundle for spi_xfer_ctrl.
interface spi_xfer_ctrl_if
    import spi_pkg::*;
#(
    parameter int unsigned DivWidth = DIV_WIDTH
);
    logic                Start;
    logic                Dir;
    logic                CPOL;
    logic [DivWidth-1:0] ClkDiv;
    logic                Busy;
    logic                Done;
    logic                CSn;
    logic                SCLK;
    logic                EnPISO;
    logic                LoadPISO;
    logic                SCLKEdgeFlg;
    logic                WordFlg;
    logic                TristateMode;

    modport master (
        output Start, Dir, CPOL, ClkDiv,
        input  Busy, Done, CSn, SCLK, EnPISO, LoadPISO, SCLKEdgeFlg, WordFlg, TristateMode
    );

    modport slave (
        input  Start, Dir, CPOL, ClkDiv,
        output Busy, Done, CSn, SCLK, EnPISO, LoadPISO, SCLKEdgeFlg, WordFlg, TristateMode
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: half period of div_i+1 clk cycles while running, follows
// the live CPOL while idle, flags the toggle that returns SCLK to idle.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DivWidth = DIV_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                idle_i,
    input  logic                run_i,
    input  logic                cpol_live_i,
    input  logic                cpol_i,
    input  logic [DivWidth-1:0] div_i,
    output logic                sclk_o,
    output logic                trail_o
);
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic                sclk_q, sclk_d;
    logic                tc;

    assign tc      = run_i && (cnt_q == div_i);
    assign trail_o = tc && (sclk_q != cpol_i);
    assign sclk_o  = sclk_q;

    // Counter wraps at the terminal compare, so ClkDiv at all-ones never overflows.
    always_comb begin
        cnt_d = '0;
        if (run_i && !tc) begin
            cnt_d = cnt_q + DivWidth'(1);
        end
    end

    always_comb begin
        sclk_d = sclk_q;
        if (idle_i) begin
            sclk_d = cpol_live_i;
        end else if (tc) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// One-word SPI master sequencer: IDLE -> LOAD -> SHIFT -> DONE -> IDLE,
// drives chip select, SCLK and the shift register control strobes.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned WordLen  = WORD_LEN,
    parameter int unsigned DivWidth = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    spi_xfer_ctrl_if.slave bus
);
    localparam int unsigned BitW = $clog2(WordLen + 1);

    xfer_state_e         state_q, state_d;
    logic                dir_q, cpol_q;
    logic [DivWidth-1:0] div_q;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic                word_flg_q, word_flg_d;
    logic                start_acc, trail, last_bit, sclk;
    logic                busy, done, csn, en_piso, load_piso;

    assign start_acc = (state_q == ST_IDLE) && bus.Start;
    assign last_bit  = trail && (bit_cnt_q == BitW'(WordLen - 1));

    spi_sclk_gen #(
        .DivWidth (DivWidth)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .idle_i      (state_q == ST_IDLE),
        .run_i       (state_q == ST_SHIFT),
        .cpol_live_i (bus.CPOL),
        .cpol_i      (cpol_q),
        .div_i       (div_q),
        .sclk_o      (sclk),
        .trail_o     (trail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.Start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        csn       = 1'b1;
        en_piso   = 1'b0;
        load_piso = 1'b0;
        case (state_q)
            ST_LOAD: begin
                busy      = 1'b1;
                csn       = 1'b0;
                en_piso   = 1'b1;
                load_piso = dir_q;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                csn     = 1'b0;
                en_piso = 1'b1;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                csn     = 1'b0;
                en_piso = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (state_q == ST_LOAD) begin
            bit_cnt_d = '0;
        end else if (trail) begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
        end
    end

    // Cleared on the edge into LOAD so it already reads 0 during LOAD.
    always_comb begin
        word_flg_d = word_flg_q;
        if (start_acc) begin
            word_flg_d = 1'b0;
        end else if (last_bit) begin
            word_flg_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= 1'b0;
            cpol_q     <= 1'b0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            word_flg_q <= 1'b0;
        end else begin
            if (start_acc) begin
                dir_q  <= bus.Dir;
                cpol_q <= bus.CPOL;
                div_q  <= bus.ClkDiv;
            end
            bit_cnt_q  <= bit_cnt_d;
            word_flg_q <= word_flg_d;
        end
    end

    assign bus.Busy         = busy;
    assign bus.Done         = done;
    assign bus.CSn          = csn;
    assign bus.SCLK         = sclk;
    assign bus.EnPISO       = en_piso;
    assign bus.LoadPISO     = load_piso;
    assign bus.SCLKEdgeFlg  = trail;
    assign bus.WordFlg      = word_flg_q;
    assign bus.TristateMode = dir_q;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: accepted Starts are queued with their
// latched settings and checked against LOAD, edge flags, SCLK and Done.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    localparam int WL = 8;

    typedef struct {
        int start;
        int div;
        bit dir;
        bit cpol;
    } xfer_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    xfer_t sb[$];
    xfer_t cur;
    bit    cur_active = 0;
    int    model_done = -1;
    int    flg_cnt = 0;
    int    next_flg = 0;
    int    last_tog = 0;
    int    check_idle_at = -1;
    int    done_cnt = 0;
    int    busy_falls = 0;
    int    last_load_cyc = 0;
    int    last_done_cyc = 0;
    logic  busy_prev = 1'b0;
    logic  prev_sclk = 1'b0;

    spi_xfer_ctrl_if #(.DivWidth(8)) bus ();

    spi_xfer_ctrl #(
        .WordLen  (WL),
        .DivWidth (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor then model, both on the falling edge.
    initial forever begin
        @(negedge clk);
        if (check_idle_at == cyc) begin
            chk("csn_after_done", bus.CSn, 1);
            chk("busy_after_done", bus.Busy, 0);
        end
        if (bus.Busy && !busy_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_load", bus.Busy, 0);
            end else begin
                cur = sb.pop_front();
                cur_active = 1;
                chk("load_cyc", cyc, cur.start + 1);
                chk("load_piso", bus.LoadPISO, cur.dir);
                chk("tristate", bus.TristateMode, cur.dir);
                chk("wordflg_load", bus.WordFlg, 0);
                chk("csn_load", bus.CSn, 0);
                chk("en_load", bus.EnPISO, 1);
                flg_cnt = 0;
                next_flg = cyc + 2 * (cur.div + 1);
                last_tog = cyc + 1;
                last_load_cyc = cyc;
            end
        end else begin
            if (bus.LoadPISO) chk("loadpiso_stray", bus.LoadPISO, 0);
            if (!cur_active && bus.SCLKEdgeFlg) chk("edge_stray", bus.SCLKEdgeFlg, 0);
            if (cur_active && bus.SCLKEdgeFlg) begin
                chk("edge_cyc", cyc, next_flg);
                chk("sclk_active", bus.SCLK, !cur.cpol);
                flg_cnt++;
                next_flg += 2 * (cur.div + 1);
            end
            if (cur_active && bus.SCLK !== prev_sclk) begin
                chk("half_period", cyc - last_tog, cur.div + 1);
                last_tog = cyc;
            end
            if (bus.Done) begin
                if (!cur_active) begin
                    chk("spurious_done", bus.Done, 0);
                end else begin
                    chk("done_cyc", cyc, cur.start + 2 + 2 * WL * (cur.div + 1));
                    chk("edge_count", flg_cnt, WL);
                    chk("wordflg_done", bus.WordFlg, 1);
                    chk("sclk_idle_done", bus.SCLK, cur.cpol);
                    chk("csn_done", bus.CSn, 0);
                    cur_active = 0;
                    check_idle_at = cyc + 1;
                    last_done_cyc = cyc;
                    done_cnt++;
                end
            end
        end
        if (busy_prev && !bus.Busy) busy_falls++;
        busy_prev = bus.Busy;
        prev_sclk = bus.SCLK;

        if (rst) begin
            sb.delete();
            cur_active = 0;
            check_idle_at = -1;
            model_done = cyc;
        end else if (cyc > model_done && bus.Start) begin
            sb.push_back('{start: cyc, div: int'(bus.ClkDiv), dir: bus.Dir, cpol: bus.CPOL});
            model_done = cyc + 2 + 2 * WL * (int'(bus.ClkDiv) + 1);
        end
    end

    task automatic wait_done(input int budget);
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt, target);
    endtask

    task automatic pulse_start(input bit dir, input bit cpol, input int div);
        @(posedge clk); #1;
        bus.Dir    = dir;
        bus.CPOL   = cpol;
        bus.ClkDiv = 8'(div);
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start  = 1'b0;
    endtask

    initial begin
        int d0;
        int b0;
        int d1;
        rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.Dir    = 1'b0;
        bus.CPOL   = 1'b0;
        bus.ClkDiv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_csn", bus.CSn, 1);
        chk("rst_sclk", bus.SCLK, 0);
        chk("rst_en", bus.EnPISO, 0);
        chk("rst_load", bus.LoadPISO, 0);
        chk("rst_wordflg", bus.WordFlg, 0);
        chk("rst_tristate", bus.TristateMode, 0);
        rst = 1'b0;

        // TX, ClkDiv=1, CPOL=0
        pulse_start(1'b1, 1'b0, 1);
        wait_done(100);
        repeat (3) @(posedge clk);

        // RX, ClkDiv=0, CPOL=1; SCLK follows CPOL while idle
        @(posedge clk); #1;
        bus.CPOL = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("sclk_idle_cpol1", bus.SCLK, 1);
        pulse_start(1'b0, 1'b1, 0);
        wait_done(100);
        repeat (2) @(posedge clk);
        #1;
        chk("rx_tristate", bus.TristateMode, 0);
        bus.CPOL = 1'b0;
        repeat (3) @(posedge clk);

        // Start pulses and setting changes mid-transfer are ignored
        d0 = done_cnt;
        b0 = busy_falls;
        pulse_start(1'b1, 1'b0, 2);
        repeat (3) @(posedge clk);
        #1;
        bus.Start = 1'b1; bus.Dir = 1'b0; bus.CPOL = 1'b1; bus.ClkDiv = 8'd0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        bus.Start = 1'b1; bus.Dir = 1'b1; bus.CPOL = 1'b0; bus.ClkDiv = 8'd2;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_done(200);
        repeat (10) @(posedge clk);
        chk("one_done", done_cnt - d0, 1);
        chk("busy_falls_once", busy_falls - b0, 1);

        // Back-to-back with Start held high
        @(posedge clk); #1;
        bus.Dir = 1'b1; bus.CPOL = 1'b0; bus.ClkDiv = 8'd0;
        bus.Start = 1'b1;
        wait_done(100);
        d1 = last_done_cyc;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        wait_done(100);
        chk("b2b_gap", last_load_cyc - d1, 2);
        repeat (3) @(posedge clk);

        // Maximum divider
        pulse_start(1'b1, 1'b0, 255);
        wait_done(5000);
        repeat (3) @(posedge clk);

        // Reset mid-SHIFT aborts without Done
        pulse_start(1'b1, 1'b0, 3);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        d0 = done_cnt;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_csn", bus.CSn, 1);
            chk("abort_busy", bus.Busy, 0);
            chk("abort_sclk", bus.SCLK, 0);
            chk("abort_edge", bus.SCLKEdgeFlg, 0);
            chk("abort_wordflg", bus.WordFlg, 0);
            chk("abort_en", bus.EnPISO, 0);
            chk("abort_done", bus.Done, 0);
            chk("abort_tristate", bus.TristateMode, 0);
        end
        rst = 1'b0;
        repeat (60) @(posedge clk);
        chk("no_done_after_abort", done_cnt, d0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
